// File: rtl/ir_object_counter_if.sv
// IR object counter: sensor/control inputs and count/status outputs.
// Master drives the sensor line and controls; slave is the counter.
interface ir_object_counter_if;
  logic       ir_i;
  logic       enable_i;
  logic       clear_i;
  logic [9:0] count_o;
  logic       pulse_o;
  logic       present_o;
  logic       overflow_o;

  modport master (
    output ir_i,
    output enable_i,
    output clear_i,
    input  count_o,
    input  pulse_o,
    input  present_o,
    input  overflow_o
  );

  modport slave (
    input  ir_i,
    input  enable_i,
    input  clear_i,
    output count_o,
    output pulse_o,
    output present_o,
    output overflow_o
  );
endinterface

// File: rtl/ir_object_counter.sv
// IR obstacle-sensor front-end: sync, debounce, presence FSM and
// a 10-bit arrival counter that drives the LCD count input.
module ir_object_counter #(
  parameter int CLOCK_FREQ    = 50_000_000,
  parameter int DEBOUNCE_US   = 2000,
  parameter int IR_ACTIVE_LOW = 1,
  parameter int MAX_COUNT     = 999,
  parameter int WRAP          = 0
) (
  input  logic clk,
  input  logic rst_n,
  ir_object_counter_if.slave bus
);

  localparam int DEB = CLOCK_FREQ / 1_000_000 * DEBOUNCE_US;
  localparam int DW  = $clog2(DEB) + 1;

  localparam logic            IDLE  = (IR_ACTIVE_LOW != 0);
  localparam logic [DW-1:0]   DLAST = DW'(DEB - 1);
  localparam logic [DW-1:0]   DONE  = DW'(1);
  localparam logic [9:0]      CMAX  = 10'(MAX_COUNT);

  typedef enum logic [1:0] {
    CLEAR,
    ARMING,
    PRESENT,
    LEAVING
  } state_t;

  logic          s1_q;
  logic          s2_q;
  logic          act;
  state_t        state_q;
  state_t        state_d;
  logic [DW-1:0] dcnt_q;
  logic [DW-1:0] dcnt_d;
  logic          arrive;
  logic          pres_d;

  logic [9:0]    count_q;
  logic          pulse_q;
  logic          present_q;
  logic          ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= IDLE;
      s2_q <= IDLE;
    end else begin
      s1_q <= bus.ir_i;
      s2_q <= s1_q;
    end
  end

  // act is 1 whenever an object blocks the beam
  assign act = s2_q ^ IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    arrive  = 1'b0;
    unique case (state_q)
      CLEAR: begin
        dcnt_d = '0;
        if (act) begin
          state_d = ARMING;
          dcnt_d  = DONE;
        end
      end
      ARMING: begin
        if (!act) begin
          state_d = CLEAR;
          dcnt_d  = '0;
        end else if (dcnt_q == DLAST) begin
          state_d = PRESENT;
          dcnt_d  = '0;
          arrive  = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      PRESENT: begin
        dcnt_d = '0;
        if (!act) begin
          state_d = LEAVING;
          dcnt_d  = DONE;
        end
      end
      LEAVING: begin
        if (act) begin
          state_d = PRESENT;
          dcnt_d  = '0;
        end else if (dcnt_q == DLAST) begin
          state_d = CLEAR;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = CLEAR;
        dcnt_d  = '0;
      end
    endcase
  end

  assign pres_d = (state_d == PRESENT)
               || (state_d == LEAVING);

  // clear dominates an arrival on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      pulse_q   <= 1'b0;
      present_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      pulse_q   <= 1'b0;
      present_q <= pres_d;
      if (bus.clear_i) begin
        count_q <= '0;
        ovf_q   <= 1'b0;
      end else if (arrive && bus.enable_i) begin
        pulse_q <= 1'b1;
        if (count_q < CMAX) begin
          count_q <= count_q + 10'd1;
        end else begin
          ovf_q <= 1'b1;
          if (WRAP != 0) begin
            count_q <= '0;
          end
        end
      end
    end
  end

  assign bus.count_o    = count_q;
  assign bus.pulse_o    = pulse_q;
  assign bus.present_o  = present_q;
  assign bus.overflow_o = ovf_q;

endmodule

// File: tb/tb_ir_object_counter.sv
// Directed bench for ir_object_counter with DEB=8 and MAX_COUNT=3,
// one saturating and one wrapping instance on shared stimulus.
module tb_ir_object_counter;

  logic clk;
  logic rst_n;
  logic ir;
  logic en;
  logic clr;

  int ntot;
  int npass;
  int np_a;
  int np_b;
  int base;
  int drops;

  ir_object_counter_if ia ();
  ir_object_counter_if ib ();

  assign ia.ir_i     = ir;
  assign ia.enable_i = en;
  assign ia.clear_i  = clr;
  assign ib.ir_i     = ir;
  assign ib.enable_i = en;
  assign ib.clear_i  = clr;

  ir_object_counter #(
    .CLOCK_FREQ(1_000_000),
    .DEBOUNCE_US(8),
    .IR_ACTIVE_LOW(1),
    .MAX_COUNT(3),
    .WRAP(0)
  ) u_a (
    .clk(clk),
    .rst_n(rst_n),
    .bus(ia)
  );

  ir_object_counter #(
    .CLOCK_FREQ(1_000_000),
    .DEBOUNCE_US(8),
    .IR_ACTIVE_LOW(1),
    .MAX_COUNT(3),
    .WRAP(1)
  ) u_b (
    .clk(clk),
    .rst_n(rst_n),
    .bus(ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ia.pulse_o) np_a++;
    if (ib.pulse_o) np_b++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    ntot++;
    if (got == exp) npass++;
    else $display("FAIL %s: got %0d want %0d", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    cyc();
  endtask

  task automatic obj();
    ir = 1'b0;
    repeat (12) cyc();
    ir = 1'b1;
    repeat (12) cyc();
  endtask

  int exp_a[5] = '{1, 2, 3, 3, 3};
  int exp_b[5] = '{1, 2, 3, 0, 1};
  int exp_o[5] = '{0, 0, 0, 1, 1};

  initial begin
    ntot  = 0;
    npass = 0;
    np_a  = 0;
    np_b  = 0;
    rst_n = 1'b0;
    ir    = 1'b1;
    en    = 1'b1;
    clr   = 1'b0;
    repeat (3) cyc();
    chk("rst_count", ia.count_o, 0);
    chk("rst_pulse", ia.pulse_o, 0);
    chk("rst_present", ia.present_o, 0);
    chk("rst_ovf", ia.overflow_o, 0);
    rst_n = 1'b1;
    repeat (3) cyc();

    // 1: clean object, latency of rise and fall
    base = np_a;
    ir = 1'b0;
    for (int j = 1; j <= 30; j++) begin
      cyc();
      if (j == 9) chk("t1_pulse_early", ia.pulse_o, 0);
      if (j == 9) chk("t1_pres_early", ia.present_o, 0);
      if (j == 10) chk("t1_pulse", ia.pulse_o, 1);
      if (j == 10) chk("t1_pres", ia.present_o, 1);
      if (j == 10) chk("t1_count", ia.count_o, 1);
      if (j == 11) chk("t1_pulse_end", ia.pulse_o, 0);
    end
    ir = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      cyc();
      if (j == 9) chk("t1_pres_hold", ia.present_o, 1);
      if (j == 10) chk("t1_pres_fall", ia.present_o, 0);
    end
    chk("t1_npulse", np_a - base, 1);

    // 2: short glitches are rejected
    do_clear();
    chk("t2_clr", ia.count_o, 0);
    base  = np_a;
    drops = 0;
    for (int g = 0; g < 3; g++) begin
      ir = 1'b0;
      repeat (5) begin
        cyc();
        if (ia.present_o) drops++;
      end
      ir = 1'b1;
      repeat (20) begin
        cyc();
        if (ia.present_o) drops++;
      end
    end
    chk("t2_count", ia.count_o, 0);
    chk("t2_npulse", np_a - base, 0);
    chk("t2_present", drops, 0);

    // 3: short dropout inside one object
    do_clear();
    base  = np_a;
    drops = 0;
    for (int j = 1; j <= 40; j++) begin
      ir = (j > 18 && j <= 22) ? 1'b1 : 1'b0;
      cyc();
      if (j >= 10 && !ia.present_o) drops++;
    end
    ir = 1'b1;
    repeat (14) cyc();
    chk("t3_count", ia.count_o, 1);
    chk("t3_npulse", np_a - base, 1);
    chk("t3_drops", drops, 0);

    // 4: saturate vs wrap at MAX_COUNT
    do_clear();
    base = np_b;
    for (int n = 0; n < 5; n++) begin
      obj();
      chk($sformatf("t4_sat%0d", n), ia.count_o, exp_a[n]);
      chk($sformatf("t4_wrap%0d", n), ib.count_o, exp_b[n]);
      chk($sformatf("t4_ovfa%0d", n), ia.overflow_o, exp_o[n]);
      chk($sformatf("t4_ovfb%0d", n), ib.overflow_o, exp_o[n]);
    end
    chk("t4_npulse", np_b - base, 5);

    // 5: enable gating, then clear racing an arrival
    do_clear();
    chk("t5_ovf_clr", ia.overflow_o, 0);
    base = np_a;
    en = 1'b0;
    obj();
    obj();
    chk("t5_gated", ia.count_o, 0);
    en = 1'b1;
    obj();
    chk("t5_count", ia.count_o, 1);
    chk("t5_npulse", np_a - base, 1);
    ir = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      clr = (j == 10) ? 1'b1 : 1'b0;
      cyc();
      if (j == 10) chk("t5_clr_pulse", ia.pulse_o, 0);
      if (j == 10) chk("t5_clr_count", ia.count_o, 0);
      if (j == 10) chk("t5_clr_ovf", ia.overflow_o, 0);
      if (j == 10) chk("t5_clr_pres", ia.present_o, 1);
    end
    clr = 1'b0;
    ir = 1'b1;
    repeat (12) cyc();
    chk("t5_npulse2", np_a - base, 1);

    // 6: reset mid-debounce, sensor held through release
    obj();
    base = np_a;
    ir = 1'b0;
    repeat (7) cyc();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_count", ia.count_o, 0);
    chk("t6_rst_pulse", ia.pulse_o, 0);
    chk("t6_rst_pres", ia.present_o, 0);
    chk("t6_rst_ovf", ia.overflow_o, 0);
    repeat (3) cyc();
    rst_n = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      cyc();
      if (j == 9) chk("t6_pulse_early", ia.pulse_o, 0);
      if (j == 10) chk("t6_pulse", ia.pulse_o, 1);
      if (j == 10) chk("t6_count", ia.count_o, 1);
    end
    chk("t6_npulse", np_a - base, 1);
    ir = 1'b1;
    repeat (12) cyc();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/ir_object_counter.md
Name: ir_object_counter

Overview:
Front-end for the infrared part-counting path. Takes the raw IR obstacle-sensor line, synchronises and debounces it, and tracks object presence with a four-state FSM. Each confirmed object arrival increments a 10-bit count. That count feeds the LCD1602 display controller's `in` port directly, replacing the current scheme of clocking a counter from the raw sensor pin.

Parameters:
- CLOCK_FREQ, 50_000_000: system clock frequency in Hz.
- DEBOUNCE_US, 2000: required stable time in microseconds. DEB = CLOCK_FREQ/1_000_000*DEBOUNCE_US cycles (localparam, must be ≥ 2).
- IR_ACTIVE_LOW, 1: 1 means ir_i low = object present; 0 means high = present.
- MAX_COUNT, 999: highest count value; must be < 1024.
- WRAP, 0: 0 = saturate at MAX_COUNT; 1 = wrap to 0.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ir_i  input  1  raw IR sensor line, asynchronous to clk
- enable_i  input  1  synchronous; 1 = confirmed arrivals are counted
- clear_i  input  1  synchronous; 1 = zero the count and overflow flag
- count_o  output  10  current object count, fed to the LCD `in` port
- pulse_o  output  1  one-cycle strobe on each counted arrival
- present_o  output  1  debounced object-present level
- overflow_o  output  1  sticky flag; set when an increment is attempted at MAX_COUNT

Behaviour:
- Reset (rst_n low, asynchronous):
  - Sync flops are set to the inactive level; FSM goes to CLEAR; debounce counter = 0.
  - count_o = 0, pulse_o = 0, present_o = 0, overflow_o = 0.
- Synchroniser:
  - Two-flop synchroniser on ir_i, followed by polarity normalisation to act = 1 when an object is present.
  - Only the second-stage output feeds the FSM.
- FSM states, with debounce counter dcnt (width clog2(DEB)+1):
  - CLEAR: dcnt = 0. act = 1 → ARMING, dcnt = 1.
  - ARMING: act = 0 → CLEAR, dcnt = 0. act = 1 and dcnt = DEB-1 → PRESENT (arrival confirmed). Otherwise dcnt += 1.
  - PRESENT: act = 0 → LEAVING, dcnt = 1.
  - LEAVING: act = 1 → PRESENT, dcnt = 0, no new count. act = 0 and dcnt = DEB-1 → CLEAR. Otherwise dcnt += 1.
- present_o:
  - 1 in PRESENT and LEAVING; 0 in CLEAR and ARMING.
  - All outputs are registered.
- Latency:
  - If ir_i is first captured active at edge k, present_o and pulse_o rise at edge k+DEB+1.
  - present_o falls DEB+1 edges after ir_i is first captured inactive.
- Arrival event (ARMING→PRESENT transition), evaluated in this priority order:
  - clear_i = 1 → count_o = 0, overflow_o = 0, pulse_o = 0. clear_i wins over any simultaneous arrival.
  - enable_i = 0 → no change to count_o; pulse_o = 0. The FSM still advances.
  - count_o < MAX_COUNT → count_o += 1, pulse_o = 1 for exactly one cycle.
  - count_o = MAX_COUNT, WRAP = 0 → count_o holds, overflow_o = 1, pulse_o = 1.
  - count_o = MAX_COUNT, WRAP = 1 → count_o = 0, overflow_o = 1, pulse_o = 1.
- clear_i outside an arrival event: takes effect on the next edge and does not disturb FSM state.
- Glitch rejection:
  - An active pulse shorter than DEB synchronised cycles never leaves ARMING and is not counted.
  - An inactive dropout shorter than DEB cycles while present never reaches CLEAR, so it cannot cause a double count.
- One object produces at most one count. A new count requires passing through CLEAR.
- Reset mid-debounce discards all progress; no count is emitted after reset deasserts.
- A sensor held active through reset release is counted once, after DEB+1 cycles.

Test Plan (bench uses CLOCK_FREQ=1_000_000, DEBOUNCE_US=8, so DEB=8):
1. Reset, then ir_i low (active-low) for 30 cycles, then high for 30 cycles → pulse_o high for 1 cycle at edge k+9; count_o = 1; present_o falls 9 edges after release.
2. Three 5-cycle low glitches separated by 20 cycles high → count_o = 0, pulse_o never asserts, present_o stays 0.
3. Object held low for 40 cycles with one 4-cycle high dropout in the middle → count_o = 1 (no double count); present_o stays 1 throughout.
4. MAX_COUNT=3, WRAP=0, five clean objects → count_o = 1,2,3,3,3; overflow_o sets on the 4th arrival and stays set. Rerun with WRAP=1 → count_o = 1,2,3,0,1; overflow_o = 1.
5. enable_i = 0 for objects 1–2, then 1 for object 3 → count_o = 1; pulse_o asserts only once. Then assert clear_i on the same cycle as a 4th arrival → count_o = 0, overflow_o = 0, no pulse.
6. Assert rst_n low for 3 cycles at dcnt = 5 in ARMING with ir_i held low → all outputs read 0 during reset; after release, pulse_o fires exactly once, 9 edges after first capture; count_o = 1.
